// File: rtl/iob_fifo_sync_asym_ctrl.sv
// Control logic for a synchronous FIFO with an asymmetric external RAM:
// narrow write words, wide read words made of R consecutive writes.
module iob_fifo_sync_asym_ctrl #(
    parameter int W_DATA_W = 8,
    parameter int R_DATA_W = 32,
    parameter int ADDR_W   = 4,
    parameter int R        = R_DATA_W / W_DATA_W,
    parameter int W_ADDR_W = ADDR_W,
    parameter int R_ADDR_W = ADDR_W - $clog2(R)
) (
    input  logic                clk_i,
    input  logic                rstn_i,

    input  logic                w_en_i,
    input  logic [W_DATA_W-1:0] w_data_i,
    output logic                w_full_o,

    input  logic                r_en_i,
    output logic [R_DATA_W-1:0] r_data_o,
    output logic                r_valid_o,
    output logic                r_empty_o,

    output logic [ADDR_W:0]     level_o,

    output logic                ext_w_en_o,
    output logic [W_ADDR_W-1:0] ext_w_addr_o,
    output logic [W_DATA_W-1:0] ext_w_data_o,
    output logic                ext_r_en_o,
    output logic [R_ADDR_W-1:0] ext_r_addr_o,
    input  logic [R_DATA_W-1:0] ext_r_data_i
);

    localparam logic [ADDR_W:0] FULL_LEVEL = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] R_LEVEL    = (ADDR_W + 1)'(R);
    localparam logic [ADDR_W:0] ONE_LEVEL  = (ADDR_W + 1)'(1);

    logic [W_ADDR_W-1:0] w_ptr;
    logic [R_ADDR_W-1:0] r_ptr;
    logic [ADDR_W:0]     level;
    logic [ADDR_W:0]     level_nxt;
    logic                wr_acc;
    logic                rd_acc;

    // Flags come straight from the registered level, so a same-cycle read
    // at full never lets a write through in that cycle.
    assign w_full_o  = (level == FULL_LEVEL);
    assign r_empty_o = (level < R_LEVEL);
    assign level_o   = level;

    assign wr_acc = w_en_i & ~w_full_o & rstn_i;
    assign rd_acc = r_en_i & ~r_empty_o & rstn_i;

    assign ext_w_en_o   = wr_acc;
    assign ext_w_addr_o = w_ptr;
    assign ext_w_data_o = w_data_i;
    assign ext_r_en_o   = rd_acc;
    assign ext_r_addr_o = r_ptr;
    assign r_data_o     = ext_r_data_i;

    always_comb begin
        level_nxt = level;
        if (wr_acc && !rd_acc) begin
            level_nxt = level + ONE_LEVEL;
        end else if (rd_acc && !wr_acc) begin
            level_nxt = level - R_LEVEL;
        end else if (wr_acc && rd_acc) begin
            level_nxt = level + ONE_LEVEL - R_LEVEL;
        end
    end

    // Pointers wrap naturally at their width; the RAM maps read address
    // r_ptr onto write addresses r_ptr*R .. r_ptr*R+R-1.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            w_ptr     <= '0;
            r_ptr     <= '0;
            level     <= '0;
            r_valid_o <= 1'b0;
        end else begin
            if (wr_acc) begin
                w_ptr <= w_ptr + W_ADDR_W'(1);
            end
            if (rd_acc) begin
                r_ptr <= r_ptr + R_ADDR_W'(1);
            end
            level     <= level_nxt;
            r_valid_o <= rd_acc;
        end
    end

endmodule

// File: tb/tb_iob_fifo_sync_asym_ctrl.sv
// Randomized scoreboard bench for iob_fifo_sync_asym_ctrl: an 8->32 bit
// instance with a behavioural RAM, plus a small 16->16 bit symmetric instance.
module tb_iob_fifo_sync_asym_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- 8 -> 32 bit instance, 16 byte deep ----------------
    logic        rstn = 1'b0;
    logic        w_en = 1'b0;
    logic [7:0]  w_data = '0;
    logic        r_en = 1'b0;
    logic        w_full, r_valid, r_empty, ext_w_en, ext_r_en;
    logic [31:0] r_data, ext_r_data;
    logic [4:0]  level;
    logic [3:0]  ext_w_addr;
    logic [7:0]  ext_w_data;
    logic [1:0]  ext_r_addr;

    iob_fifo_sync_asym_ctrl #(.W_DATA_W(8), .R_DATA_W(32), .ADDR_W(4)) dut (
        .clk_i(clk), .rstn_i(rstn),
        .w_en_i(w_en), .w_data_i(w_data), .w_full_o(w_full),
        .r_en_i(r_en), .r_data_o(r_data), .r_valid_o(r_valid), .r_empty_o(r_empty),
        .level_o(level),
        .ext_w_en_o(ext_w_en), .ext_w_addr_o(ext_w_addr), .ext_w_data_o(ext_w_data),
        .ext_r_en_o(ext_r_en), .ext_r_addr_o(ext_r_addr), .ext_r_data_i(ext_r_data)
    );

    logic [7:0] mem [16];
    always @(posedge clk) begin
        if (ext_w_en) mem[ext_w_addr] <= ext_w_data;
        if (ext_r_en) begin
            for (int k = 0; k < 4; k++) ext_r_data[k*8 +: 8] <= mem[int'(ext_r_addr) * 4 + k];
        end
    end

    logic [7:0]  q[$];
    logic [31:0] expq[$];
    int          wcnt = 0;
    int          rcnt = 0;
    logic        last_racc = 1'b0;

    always @(negedge clk) begin
        if (r_valid === 1'b1) begin
            if (expq.size() == 0) begin
                check("unexpected_r_valid", 32'(r_valid), 32'd0);
            end else begin
                check("r_data", r_data, expq.pop_front());
            end
        end
    end

    task automatic applyStimulus(input logic we, input logic [7:0] wd, input logic re, input logic rn);
        logic wacc, racc;
        logic [31:0] word;
        @(negedge clk);
        w_en = we; w_data = wd; r_en = re; rstn = rn;
        #1;
        wacc = rn && we && (q.size() < 16);
        racc = rn && re && (q.size() >= 4);
        check("ext_w_en", 32'(ext_w_en), 32'(wacc));
        check("ext_r_en", 32'(ext_r_en), 32'(racc));
        check("level", 32'(level), 32'(q.size()));
        check("w_full", 32'(w_full), 32'(q.size() == 16));
        check("r_empty", 32'(r_empty), 32'(q.size() < 4));
        check("r_valid", 32'(r_valid), 32'(last_racc));
        check("ext_w_addr", 32'(ext_w_addr), 32'(wcnt % 16));
        check("ext_r_addr", 32'(ext_r_addr), 32'(rcnt % 4));
        if (wacc) check("ext_w_data", 32'(ext_w_data), 32'(wd));
        @(posedge clk);
        if (!rn) begin
            q.delete();
            wcnt = 0;
            rcnt = 0;
        end else begin
            if (racc) begin
                word = '0;
                for (int k = 0; k < 4; k++) word[k*8 +: 8] = q.pop_front();
                expq.push_back(word);
                rcnt++;
            end
            if (wacc) begin
                q.push_back(wd);
                wcnt++;
            end
        end
        last_racc = racc;
    endtask

    // ---------------- 16 -> 16 bit instance, 8 deep ----------------
    logic        rstn16 = 1'b0;
    logic        w_en16 = 1'b0;
    logic [15:0] w_data16 = '0;
    logic        r_en16 = 1'b0;
    logic        w_full16, r_valid16, r_empty16, ext_w_en16, ext_r_en16;
    logic [15:0] r_data16, ext_r_data16, ext_w_data16;
    logic [3:0]  level16;
    logic [2:0]  ext_w_addr16, ext_r_addr16;

    iob_fifo_sync_asym_ctrl #(.W_DATA_W(16), .R_DATA_W(16), .ADDR_W(3)) dut16 (
        .clk_i(clk), .rstn_i(rstn16),
        .w_en_i(w_en16), .w_data_i(w_data16), .w_full_o(w_full16),
        .r_en_i(r_en16), .r_data_o(r_data16), .r_valid_o(r_valid16), .r_empty_o(r_empty16),
        .level_o(level16),
        .ext_w_en_o(ext_w_en16), .ext_w_addr_o(ext_w_addr16), .ext_w_data_o(ext_w_data16),
        .ext_r_en_o(ext_r_en16), .ext_r_addr_o(ext_r_addr16), .ext_r_data_i(ext_r_data16)
    );

    logic [15:0] mem16 [8];
    always @(posedge clk) begin
        if (ext_w_en16) mem16[ext_w_addr16] <= ext_w_data16;
        if (ext_r_en16) ext_r_data16 <= mem16[ext_r_addr16];
    end

    logic [15:0] q16[$];
    logic [15:0] expq16[$];

    always @(negedge clk) begin
        if (r_valid16 === 1'b1) begin
            if (expq16.size() == 0) begin
                check("unexpected_r_valid16", 32'(r_valid16), 32'd0);
            end else begin
                check("r_data16", 32'(r_data16), 32'(expq16.pop_front()));
            end
        end
    end

    task automatic applyStimulus16(input logic we, input logic [15:0] wd, input logic re, input logic rn);
        logic wacc, racc;
        @(negedge clk);
        w_en16 = we; w_data16 = wd; r_en16 = re; rstn16 = rn;
        #1;
        wacc = rn && we && (q16.size() < 8);
        racc = rn && re && (q16.size() >= 1);
        check("ext_w_en16", 32'(ext_w_en16), 32'(wacc));
        check("ext_r_en16", 32'(ext_r_en16), 32'(racc));
        check("level16", 32'(level16), 32'(q16.size()));
        check("w_full16", 32'(w_full16), 32'(q16.size() == 8));
        check("r_empty16", 32'(r_empty16), 32'(q16.size() == 0));
        @(posedge clk);
        if (!rn) begin
            q16.delete();
        end else begin
            if (racc) expq16.push_back(q16.pop_front());
            if (wacc) q16.push_back(wd);
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset with requests pending: no RAM enables may appear.
        applyStimulus(1'b1, 8'hAA, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'hBB, 1'b1, 1'b0);

        // Four bytes form one little-endian word.
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
        applyStimulus(1'b1, 8'h11, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'h22, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'h33, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'h44, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

        // Fill to full, then one blocked write.
        for (int i = 0; i < 17; i++) applyStimulus(1'b1, 8'($urandom), 1'b0, 1'b1);
        applyStimulus(1'b1, 8'h5A, 1'b1, 1'b1);

        // Drain to level 4, then simultaneous write and read.
        for (int i = 0; i < 2; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
        applyStimulus(1'b1, 8'h77, 1'b1, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

        // Random traffic with rare mid-stream resets; pointers wrap many times.
        for (int i = 0; i < 600; i++) begin
            applyStimulus($urandom_range(0, 99) < 55, 8'($urandom),
                          $urandom_range(0, 99) < 30, $urandom_range(0, 199) != 0);
        end

        // Reset at level 9 with both requests asserted.
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) applyStimulus(1'b1, 8'($urandom), 1'b0, 1'b1);
        applyStimulus(1'b1, 8'hEE, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

        // Symmetric instance: fill, one blocked write, drain in order.
        applyStimulus16(1'b1, 16'h0, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) applyStimulus16(1'b1, 16'($urandom), 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) applyStimulus16(1'b0, 16'h0, 1'b1, 1'b1);
        for (int i = 0; i < 60; i++) begin
            applyStimulus16($urandom_range(0, 1) == 1, 16'($urandom), $urandom_range(0, 1) == 1, 1'b1);
        end
        for (int i = 0; i < 10; i++) applyStimulus16(1'b0, 16'h0, 1'b1, 1'b1);
        applyStimulus16(1'b0, 16'h0, 1'b0, 1'b1);

        @(negedge clk);
        @(negedge clk);
        check("pending_reads", 32'(expq.size()), 32'd0);
        check("pending_reads16", 32'(expq16.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
